// File: rtl/ex_iter_divider.sv
// ex_iter_divider: handshaked iterative radix-2 restoring divider for EX1.
// Produces quotient, remainder and the destination tag together and holds
// them in DONE until the writeback side accepts. Signed and unsigned modes,
// flush, back-to-back issue and a fixed divide-by-zero result.
// Optional build macro EX_DIV_EARLY_OUT_EN: skip the dividend's leading
// zeros, shortening the iteration count without changing any result.
module ex_iter_divider #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_div_zero,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_e;

   state_e           state_q;

   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic             opSigned_q;
   logic [TAG_W-1:0] tag_q;

   logic [WIDTH-1:0] divMag_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [CNT_W-1:0] count_q;
   logic             quoNeg_q;
   logic             remNeg_q;
   logic             divZero_q;

   logic             outValid_q;
   logic [WIDTH-1:0] outQuo_q;
   logic [WIDTH-1:0] outRem_q;
   logic [TAG_W-1:0] outTag_q;
   logic             outDivZero_q;

   logic             accept;
   logic             dividendNeg;
   logic             divisorNeg;
   logic [WIDTH-1:0] dividendMag;
   logic [WIDTH-1:0] divisorMag;
   logic [WIDTH:0]   remShift_d;
   logic [WIDTH:0]   remTrial_d;
   logic [WIDTH-1:0] remStep_d;
   logic [WIDTH-1:0] quoStep_d;
   logic [WIDTH-1:0] quoFix_d;
   logic [WIDTH-1:0] remFix_d;

   // A new operation is taken from IDLE, or from DONE in the same cycle the
   // held result is consumed, so back-to-back issue loses no cycle.
   assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept   = in_valid & in_ready;
   assign busy     = (state_q != IDLE);

   assign out_valid     = outValid_q;
   assign out_quotient  = outQuo_q;
   assign out_remainder = outRem_q;
   assign out_tag       = outTag_q;
   assign out_div_zero  = outDivZero_q;

   // Operand magnitudes for PREP; in unsigned mode nothing is negated. The
   // magnitude of MIN is MIN itself, which is correct as an unsigned value.
   always_comb begin
      dividendNeg = opSigned_q & dividend_q[WIDTH-1];
      divisorNeg  = opSigned_q & divisor_q[WIDTH-1];
      dividendMag = dividendNeg ? (~dividend_q + 1'b1) : dividend_q;
      divisorMag  = divisorNeg  ? (~divisor_q  + 1'b1) : divisor_q;
   end

   // One restoring step: shift {rem, quo} left, trial-subtract the divisor
   // and keep the difference only when it did not go negative. The trial
   // value needs one extra bit because the shifted remainder can exceed WIDTH.
   always_comb begin
      remShift_d = {rem_q, quo_q[WIDTH-1]};
      remTrial_d = remShift_d - {1'b0, divMag_q};
      if (!remTrial_d[WIDTH]) begin
         remStep_d = remTrial_d[WIDTH-1:0];
         quoStep_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         remStep_d = remShift_d[WIDTH-1:0];
         quoStep_d = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction applied in FIX: quotient takes the xor of operand signs,
   // remainder takes the dividend sign. MIN / -1 falls out as MIN rem 0.
   always_comb begin
      quoFix_d = quoNeg_q ? (~quo_q + 1'b1) : quo_q;
      remFix_d = remNeg_q ? (~rem_q + 1'b1) : rem_q;
   end

`ifdef EX_DIV_EARLY_OUT_EN
   logic [CNT_W-1:0] leadZeros;
   logic             leadFound;

   // Leading-zero count of the dividend magnitude; equals WIDTH for zero.
   always_comb begin
      leadZeros = '0;
      leadFound = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!leadFound) begin
            if (dividendMag[i]) begin
               leadFound = 1'b1;
            end else begin
               leadZeros = leadZeros + CNT_W'(1);
            end
         end
      end
   end
`endif

   // Main FSM with registered outputs. Reset clears everything; flush only
   // abandons the operation and drops out_valid, and beats any request.
   // A zero divisor passes through FIX so its result lands two cycles after
   // the request, like a zero-length iteration run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dividend_q   <= '0;
         divisor_q    <= '0;
         opSigned_q   <= 1'b0;
         tag_q        <= '0;
         divMag_q     <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         count_q      <= '0;
         quoNeg_q     <= 1'b0;
         remNeg_q     <= 1'b0;
         divZero_q    <= 1'b0;
         outValid_q   <= 1'b0;
         outQuo_q     <= '0;
         outRem_q     <= '0;
         outTag_q     <= '0;
         outDivZero_q <= 1'b0;
      end else if (flush) begin
         state_q    <= IDLE;
         outValid_q <= 1'b0;
      end else begin
         if (accept) begin
            dividend_q <= in_dividend;
            divisor_q  <= in_divisor;
            opSigned_q <= in_signed;
            tag_q      <= in_tag;
         end
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_q <= PREP;
               end
            end
            PREP: begin
               quoNeg_q <= dividendNeg ^ divisorNeg;
               remNeg_q <= dividendNeg;
               divMag_q <= divisorMag;
               rem_q    <= '0;
               if (divisor_q == '0) begin
                  divZero_q <= 1'b1;
                  quo_q     <= '0;
                  count_q   <= '0;
                  state_q   <= FIX;
               end else begin
                  divZero_q <= 1'b0;
`ifdef EX_DIV_EARLY_OUT_EN
                  quo_q   <= dividendMag << leadZeros;
                  count_q <= CNT_W'(WIDTH) - leadZeros;
                  if (leadZeros == CNT_W'(WIDTH)) begin
                     state_q <= FIX;
                  end else begin
                     state_q <= CALC;
                  end
`else
                  quo_q   <= dividendMag;
                  count_q <= CNT_W'(WIDTH);
                  state_q <= CALC;
`endif
               end
            end
            CALC: begin
               rem_q   <= remStep_d;
               quo_q   <= quoStep_d;
               count_q <= count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               outQuo_q     <= divZero_q ? '1 : quoFix_d;
               outRem_q     <= divZero_q ? dividend_q : remFix_d;
               outTag_q     <= tag_q;
               outDivZero_q <= divZero_q;
               outValid_q   <= 1'b1;
               state_q      <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  if (in_valid) begin
                     state_q <= PREP;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               outValid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_iter_divider.sv
// tb_ex_iter_divider: directed scoreboard bench for ex_iter_divider.
// Stimulus pushes hand-computed results; a monitor pops them on each
// output handshake. Latency expectations follow EX_DIV_EARLY_OUT_EN.
module tb_ex_iter_divider;

   localparam int WIDTH = 32;
   localparam int TAG_W = 5;
`ifdef EX_DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [WIDTH-1:0] quo;
      logic [WIDTH-1:0] rem;
      logic [TAG_W-1:0] tag;
      logic             dz;
      int               lat;
      int               issue;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             inValid;
   logic             inReady;
   logic             inSigned;
   logic [WIDTH-1:0] inDividend;
   logic [WIDTH-1:0] inDivisor;
   logic [TAG_W-1:0] inTag;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] outQuotient;
   logic [WIDTH-1:0] outRemainder;
   logic [TAG_W-1:0] outTag;
   logic             outDivZero;
   logic             busy;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycleCount = 0;
   int   validCycle = 0;
   logic prevValid = 1'b0;

   ex_iter_divider #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (inValid),
      .in_ready      (inReady),
      .in_signed     (inSigned),
      .in_dividend   (inDividend),
      .in_divisor    (inDivisor),
      .in_tag        (inTag),
      .out_valid     (outValid),
      .out_ready     (outReady),
      .out_quotient  (outQuotient),
      .out_remainder (outRemainder),
      .out_tag       (outTag),
      .out_div_zero  (outDivZero),
      .busy          (busy)
   );

   // Free-running clock and posedge counter used for latency measurement.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: records when out_valid rises and compares on every output
   // handshake against the oldest expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (outValid && !prevValid) validCycle = cycleCount;
         prevValid = outValid;
         if (outValid && outReady) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpected_result", 64'(outTag), 64'h1_0000);
            end else begin
               e = sbQ.pop_front();
               checkOutput("quotient", 64'(outQuotient), 64'(e.quo));
               checkOutput("remainder", 64'(outRemainder), 64'(e.rem));
               checkOutput("tag", 64'(outTag), 64'(e.tag));
               checkOutput("div_zero", 64'(outDivZero), 64'(e.dz));
               checkOutput("latency", 64'(validCycle - e.issue), 64'(e.lat));
            end
         end
      end
   end

   // Issue one request; when wantResult is set the expected response is
   // queued with the handshake edge so the monitor can check latency.
   task automatic applyStimulus(input logic sgn, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                                input bit wantResult, input logic [WIDTH-1:0] eq,
                                input logic [WIDTH-1:0] er, input logic edz,
                                input int latFull, input int latEarly);
      exp_t e;
      int   waitCnt;
      waitCnt    = 0;
      inSigned   = sgn;
      inDividend = a;
      inDivisor  = b;
      inTag      = tag;
      inValid    = 1'b1;
      @(negedge clk);
      while (!inReady && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!inReady) begin
         checkOutput("handshake_timeout", 64'(inReady), 64'd1);
         inValid = 1'b0;
         return;
      end
      if (wantResult) begin
         e.quo   = eq;
         e.rem   = er;
         e.tag   = tag;
         e.dz    = edz;
         e.lat   = EARLY ? latEarly : latFull;
         e.issue = cycleCount + 1;
         sbQ.push_back(e);
      end
      @(posedge clk);
      #1 inValid = 1'b0;
   endtask

   // Wait (bounded) until every queued result has been consumed.
   task automatic waitDrain();
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
   endtask

   // Wait (bounded) for out_valid, ending on a negedge.
   task automatic waitValid();
      int n;
      n = 0;
      @(negedge clk);
      while (!outValid && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("valid_timeout", 64'(outValid), 64'd1);
   endtask

   // Compare all outputs against their reset values.
   task automatic checkResetState(input string tagName);
      checkOutput({tagName, "_valid"}, 64'(outValid), 64'd0);
      checkOutput({tagName, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tagName, "_in_ready"}, 64'(inReady), 64'd1);
      checkOutput({tagName, "_quotient"}, 64'(outQuotient), 64'd0);
      checkOutput({tagName, "_remainder"}, 64'(outRemainder), 64'd0);
      checkOutput({tagName, "_tag"}, 64'(outTag), 64'd0);
      checkOutput({tagName, "_div_zero"}, 64'(outDivZero), 64'd0);
   endtask

   // Runaway guard.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      bit sawValid;
      rst        = 1'b1;
      flush      = 1'b0;
      inValid    = 1'b0;
      inSigned   = 1'b0;
      inDividend = '0;
      inDivisor  = '0;
      inTag      = '0;
      outReady   = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkResetState("reset");

      @(posedge clk); #1;
      $display("[TB] basic unsigned and signed divisions");
      applyStimulus(1'b0, 32'd100, 32'd7, 5'h0A, 1'b1, 32'd14, 32'd2, 1'b0, 34, 9);
      waitDrain();
      applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 5'h01, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 5);
      applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 5'h02, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 5);
      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'h03, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, 34);
      applyStimulus(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'h0D, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 34, 9);
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 5'h0C, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 34);
      waitDrain();

      $display("[TB] divide by zero");
      applyStimulus(1'b0, 32'h1234_5678, 32'd0, 5'h04, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2, 2);
      applyStimulus(1'b1, 32'hFFFF_FFFB, 32'd0, 5'h0B, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2, 2);
      waitDrain();

      $display("[TB] held result and back-to-back issue");
      @(posedge clk); #1 outReady = 1'b0;
      applyStimulus(1'b0, 32'd1000, 32'd10, 5'h06, 1'b1, 32'd100, 32'd0, 1'b0, 34, 12);
      waitValid();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 64'(outValid), 64'd1);
         checkOutput("hold_quotient", 64'(outQuotient), 64'd100);
         checkOutput("hold_in_ready", 64'(inReady), 64'd0);
      end
      @(posedge clk); #1 outReady = 1'b1;
      applyStimulus(1'b0, 32'd9, 32'd3, 5'h07, 1'b1, 32'd3, 32'd0, 1'b0, 34, 6);
      @(negedge clk);
      checkOutput("b2b_busy", 64'(busy), 64'd1);
      checkOutput("b2b_valid", 64'(outValid), 64'd0);
      waitDrain();

      $display("[TB] flush during CALC");
      applyStimulus(1'b0, 32'hFFFF_0000, 32'd5, 5'h11, 1'b0, '0, '0, 1'b0, 0, 0);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checkOutput("flush_calc_valid", 64'(outValid), 64'd0);
      checkOutput("flush_calc_busy", 64'(busy), 64'd0);
      sawValid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (outValid) sawValid = 1'b1;
      end
      checkOutput("flush_calc_no_result", 64'(sawValid), 64'd0);

      $display("[TB] flush while holding a result");
      @(posedge clk); #1 outReady = 1'b0;
      applyStimulus(1'b0, 32'hFFFF_0000, 32'd5, 5'h12, 1'b0, '0, '0, 1'b0, 0, 0);
      waitValid();
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      checkOutput("flush_done_valid", 64'(outValid), 64'd0);
      checkOutput("flush_done_busy", 64'(busy), 64'd0);
      @(posedge clk); #1 outReady = 1'b1;

      $display("[TB] flush beats a same-cycle request");
      inSigned   = 1'b0;
      inDividend = 32'd50;
      inDivisor  = 32'd5;
      inTag      = 5'h13;
      inValid    = 1'b1;
      flush      = 1'b1;
      @(negedge clk);
      checkOutput("flush_req_in_ready", 64'(inReady), 64'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      flush   = 1'b0;
      @(negedge clk);
      checkOutput("flush_req_busy", 64'(busy), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      applyStimulus(1'b0, 32'd20, 32'd6, 5'h09, 1'b1, 32'd3, 32'd2, 1'b0, 34, 7);
      waitDrain();

      $display("[TB] reset mid-operation");
      applyStimulus(1'b0, 32'hFFFF_0000, 32'd5, 5'h14, 1'b0, '0, '0, 1'b0, 0, 0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkResetState("rst_calc");
      @(posedge clk); #1 outReady = 1'b0;
      applyStimulus(1'b0, 32'hFFFF_0000, 32'd5, 5'h1F, 1'b0, '0, '0, 1'b0, 0, 0);
      waitValid();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkResetState("rst_done");
      @(posedge clk); #1 outReady = 1'b1;

      applyStimulus(1'b0, 32'd100, 32'd7, 5'h15, 1'b1, 32'd14, 32'd2, 1'b0, 34, 9);
      waitDrain();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
